// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU, branch/jump resolution, load/store addressing and an
// iterative multiply/divide unit, all feeding a registered output stage towards memory_stage.
module execute_stage #(
    parameter logic        MDU_ENABLE = 1'b1,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_bits_in,
    input  logic [31:0] program_counter_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] immediate_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_valid_in,
    input  logic        stall_in,
    output logic        stall_out,
    output logic [31:0] address_out,
    output logic [31:0] rd_data_out,
    output logic [31:0] source_data_out,
    output logic [31:0] instruction_bits_out,
    output logic [4:0]  rd_out,
    output logic        rd_valid_out,
    output logic [31:0] program_counter_out,
    output logic [31:0] next_program_counter_out,
    output logic        jump_valid_out,
    output logic [31:0] jump_address_out,
    output logic        fwd_valid_out,
    output logic [4:0]  fwd_rd_out,
    output logic [31:0] fwd_data_out
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {MDU_IDLE = 2'd0, MDU_BUSY = 2'd1, MDU_DONE = 2'd2} mdu_state_t;
    mdu_state_t state_r, state_next_s;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        is_m_s, slot_valid_s, mdu_start_s, mdu_accept_s, squash_r;
    logic [31:0] op_b_s, alu_s, result_s, target_s, addr_s, mdu_result_s;
    logic [4:0]  shamt_s;
    logic        branch_s, known_s, writes_rd_s, is_store_s, taken_s, bubble_s;
    logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s, div_sub_s, quo_s, rem_s;
    logic [32:0] mul_sum_s, div_shift_s;
    logic [63:0] acc_r, acc_step_s, prod_s;
    logic [31:0] opnd_r, dividend_r;
    logic [2:0]  f3_r;
    logic        neg_q_r, neg_r_r, div_zero_r;
    logic [4:0]  iter_r;

    logic [31:0] nxt_addr_s, nxt_data_s, nxt_src_s, nxt_instr_s, nxt_pc_s, nxt_npc_s, nxt_jaddr_s;
    logic [4:0]  nxt_rd_s;
    logic        nxt_rd_valid_s, nxt_jump_s;
    logic [31:0] addr_r, data_r, src_r, instr_r, pc_r, npc_r, jaddr_r;
    logic [4:0]  rd_r;
    logic        rd_valid_r, jump_r;

    assign opcode_s     = instruction_bits_in[6:0];
    assign funct3_s     = instruction_bits_in[14:12];
    assign is_m_s       = (opcode_s == OPC_OP) && (instruction_bits_in[31:25] == 7'b0000001);
    assign slot_valid_s = rd_valid_in && !squash_r;
    assign mdu_start_s  = (state_r == MDU_IDLE) && slot_valid_s && is_m_s && (MDU_ENABLE == 1'b1);
    assign mdu_accept_s = mdu_start_s && !stall_in;
    assign addr_s       = rs1_data_in + immediate_in;
    // DONE with stall_in is covered by the stall_in term
    assign stall_out    = !rst && (stall_in || mdu_start_s || (state_r == MDU_BUSY));

    // Integer ALU for OP / OP-IMM
    always_comb begin
        op_b_s  = (opcode_s == OPC_OP) ? rs2_data_in : immediate_in;
        shamt_s = op_b_s[4:0];
        alu_s   = 32'd0;
        case (funct3_s)
            3'b000: begin
                if ((opcode_s == OPC_OP) && instruction_bits_in[30]) alu_s = rs1_data_in - op_b_s;
                else alu_s = rs1_data_in + op_b_s;
            end
            3'b001: alu_s = rs1_data_in << shamt_s;
            3'b010: alu_s = {31'd0, $signed(rs1_data_in) < $signed(op_b_s)};
            3'b011: alu_s = {31'd0, rs1_data_in < op_b_s};
            3'b100: alu_s = rs1_data_in ^ op_b_s;
            3'b101: begin
                if (instruction_bits_in[30]) alu_s = $signed(rs1_data_in) >>> shamt_s;
                else alu_s = rs1_data_in >> shamt_s;
            end
            3'b110: alu_s = rs1_data_in | op_b_s;
            3'b111: alu_s = rs1_data_in & op_b_s;
            default: alu_s = 32'd0;
        endcase
    end

    // Branch condition
    always_comb begin
        case (funct3_s)
            3'b000:  branch_s = (rs1_data_in == rs2_data_in);
            3'b001:  branch_s = (rs1_data_in != rs2_data_in);
            3'b100:  branch_s = ($signed(rs1_data_in) < $signed(rs2_data_in));
            3'b101:  branch_s = !($signed(rs1_data_in) < $signed(rs2_data_in));
            3'b110:  branch_s = (rs1_data_in < rs2_data_in);
            3'b111:  branch_s = !(rs1_data_in < rs2_data_in);
            default: branch_s = 1'b0;
        endcase
    end

    // Opcode decode: result selection and control-flow outcome
    always_comb begin
        known_s     = 1'b1;
        writes_rd_s = 1'b0;
        is_store_s  = 1'b0;
        taken_s     = 1'b0;
        target_s    = program_counter_in + immediate_in;
        result_s    = 32'd0;
        case (opcode_s)
            OPC_OP: begin
                writes_rd_s = 1'b1;
                if (!is_m_s) result_s = alu_s;
                else if (MDU_ENABLE == 1'b1) result_s = mdu_result_s;
                else known_s = 1'b0;
            end
            OPC_OPIMM: begin writes_rd_s = 1'b1; result_s = alu_s; end
            OPC_LUI:   begin writes_rd_s = 1'b1; result_s = immediate_in; end
            OPC_AUIPC: begin writes_rd_s = 1'b1; result_s = program_counter_in + immediate_in; end
            OPC_JAL: begin
                writes_rd_s = 1'b1;
                result_s    = program_counter_in + 32'd4;
                taken_s     = 1'b1;
            end
            OPC_JALR: begin
                writes_rd_s = 1'b1;
                result_s    = program_counter_in + 32'd4;
                taken_s     = 1'b1;
                target_s    = addr_s & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: taken_s = branch_s;
            OPC_LOAD:   writes_rd_s = 1'b1;
            OPC_STORE:  is_store_s = 1'b1;
            default:    known_s = 1'b0;
        endcase
    end

    // Next output-register contents; the accept cycle and BUSY emit bubbles
    always_comb begin
        bubble_s = !slot_valid_s || !known_s || mdu_start_s || (state_r == MDU_BUSY);
        if (bubble_s) begin
            nxt_instr_s = NOP_INSTR;   nxt_pc_s = 32'd0;   nxt_npc_s = 32'd0;
            nxt_addr_s = 32'd0;        nxt_data_s = 32'd0; nxt_src_s = 32'd0;
            nxt_rd_s = 5'd0;           nxt_rd_valid_s = 1'b0;
            nxt_jump_s = 1'b0;         nxt_jaddr_s = 32'd0;
        end else begin
            nxt_instr_s    = instruction_bits_in;
            nxt_pc_s       = program_counter_in;
            nxt_npc_s      = taken_s ? target_s : (program_counter_in + 32'd4);
            nxt_addr_s     = addr_s;
            nxt_src_s      = rs2_data_in;
            nxt_rd_s       = rd_in;
            nxt_rd_valid_s = writes_rd_s && (rd_in != 5'd0);
            nxt_jump_s     = taken_s;
            nxt_jaddr_s    = taken_s ? target_s : 32'd0;
            if (is_store_s) nxt_data_s = rs2_data_in;
            else if (rd_in == 5'd0) nxt_data_s = 32'd0;
            else nxt_data_s = result_s;
        end
    end

    // Output register; jump pulse lasts one cycle and arms the wrong-path squash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= NOP_INSTR; pc_r <= 32'd0; npc_r <= 32'd0; addr_r <= 32'd0;
            data_r <= 32'd0; src_r <= 32'd0; rd_r <= 5'd0; rd_valid_r <= 1'b0;
            jump_r <= 1'b0; jaddr_r <= 32'd0; squash_r <= 1'b0;
        end else if (!stall_in) begin
            instr_r <= nxt_instr_s; pc_r <= nxt_pc_s; npc_r <= nxt_npc_s; addr_r <= nxt_addr_s;
            data_r <= nxt_data_s; src_r <= nxt_src_s; rd_r <= nxt_rd_s; rd_valid_r <= nxt_rd_valid_s;
            jump_r <= nxt_jump_s; jaddr_r <= nxt_jaddr_s; squash_r <= nxt_jump_s;
        end else begin
            jump_r <= 1'b0;
        end
    end

    assign instruction_bits_out     = instr_r;
    assign program_counter_out      = pc_r;
    assign next_program_counter_out = npc_r;
    assign address_out              = addr_r;
    assign rd_data_out              = data_r;
    assign source_data_out          = src_r;
    assign rd_out                   = rd_r;
    assign rd_valid_out             = rd_valid_r;
    assign jump_valid_out           = jump_r;
    assign jump_address_out         = jaddr_r;
    assign fwd_valid_out            = rd_valid_r;
    assign fwd_rd_out               = rd_r;
    assign fwd_data_out             = data_r;

    // MDU operand magnitudes and signs; funct3 picks signedness per operand
    always_comb begin
        a_signed_s = (funct3_s != 3'b011) && (funct3_s != 3'b101) && (funct3_s != 3'b111);
        b_signed_s = a_signed_s && (funct3_s != 3'b010);
        a_neg_s    = a_signed_s && rs1_data_in[31];
        b_neg_s    = b_signed_s && rs2_data_in[31];
        a_mag_s    = a_neg_s ? (32'd0 - rs1_data_in) : rs1_data_in;
        b_mag_s    = b_neg_s ? (32'd0 - rs2_data_in) : rs2_data_in;
    end

    // One shift-add or restoring-divide iteration; acc holds {hi/rem, lo/quotient}
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        div_shift_s = {acc_r[63:32], acc_r[31]};
        div_sub_s   = div_shift_s[31:0] - opnd_r;
        if (!f3_r[2]) acc_step_s = {mul_sum_s, acc_r[31:1]};
        else if (div_shift_s >= {1'b0, opnd_r}) acc_step_s = {div_sub_s, acc_r[30:0], 1'b1};
        else acc_step_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
    end

    // Sign correction and special divide cases
    always_comb begin
        prod_s = neg_q_r ? (64'd0 - acc_r) : acc_r;
        if (div_zero_r) quo_s = 32'hFFFF_FFFF;
        else quo_s = neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        if (div_zero_r) rem_s = dividend_r;
        else rem_s = neg_r_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        case (f3_r)
            3'b000:                 mdu_result_s = prod_s[31:0];
            3'b001, 3'b010, 3'b011: mdu_result_s = prod_s[63:32];
            3'b100, 3'b101:         mdu_result_s = quo_s;
            3'b110, 3'b111:         mdu_result_s = rem_s;
            default:                mdu_result_s = 32'd0;
        endcase
    end

    // MDU datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= 64'd0; opnd_r <= 32'd0; dividend_r <= 32'd0; f3_r <= 3'd0;
            neg_q_r <= 1'b0; neg_r_r <= 1'b0; div_zero_r <= 1'b0; iter_r <= 5'd0;
        end else if (mdu_accept_s) begin
            f3_r       <= funct3_s;
            acc_r      <= {32'd0, funct3_s[2] ? a_mag_s : b_mag_s};
            opnd_r     <= funct3_s[2] ? b_mag_s : a_mag_s;
            dividend_r <= rs1_data_in;
            neg_q_r    <= a_neg_s ^ b_neg_s;
            neg_r_r    <= a_neg_s;
            div_zero_r <= funct3_s[2] && (rs2_data_in == 32'd0);
            iter_r     <= 5'd0;
        end else if (state_r == MDU_BUSY) begin
            acc_r  <= acc_step_s;
            iter_r <= iter_r + 5'd1;
        end
    end

    // MDU state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= MDU_IDLE;
        else state_r <= state_next_s;
    end

    // MDU next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MDU_IDLE: begin
                if (mdu_accept_s) state_next_s = MDU_BUSY;
                else state_next_s = MDU_IDLE;
            end
            MDU_BUSY: begin
                if (iter_r == 5'd31) state_next_s = MDU_DONE;
                else state_next_s = MDU_BUSY;
            end
            MDU_DONE: begin
                if (!stall_in) state_next_s = MDU_IDLE;
                else state_next_s = MDU_DONE;
            end
            default: state_next_s = MDU_IDLE;
        endcase
    end
endmodule
